// File: rtl/dict_match_pipe_if.sv
// dict_match_pipe_if
//   Groups the handshake and data signals of the dictionary match engine.
//   Signal names follow the engine's point of view (i_* into the engine,
//   o_* out of it).
//   slave  : engine side  (receives words, produces results)
//   master : driver side  (upstream producer + downstream consumer)
//   i_valid/o_ready/i_word/i_zero_hit/i_flush : input word channel
//   o_valid/i_ready/o_match_bytes/o_location/o_word : result channel
interface dict_match_pipe_if #(
  parameter int WORD       = 32,
  parameter int DICT_ENTRY = 16
);
  localparam int MBW = $clog2(WORD/8 + 1);
  localparam int LW  = $clog2(DICT_ENTRY);

  logic            i_valid;
  logic            o_ready;
  logic [WORD-1:0] i_word;
  logic            i_zero_hit;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [MBW-1:0]  o_match_bytes;
  logic [LW-1:0]   o_location;
  logic [WORD-1:0] o_word;

  modport slave (
    input  i_valid, i_word, i_zero_hit, i_flush, i_ready,
    output o_ready, o_valid, o_match_bytes, o_location, o_word
  );

  modport master (
    output i_valid, i_word, i_zero_hit, i_flush, i_ready,
    input  o_ready, o_valid, o_match_bytes, o_location, o_word
  );
endinterface

// File: rtl/dict_match_pipe.sv
// dict_match_pipe
//   Two-stage dictionary match engine for the compressor match stage.
//   Keeps a FIFO-replaced dictionary of DICT_ENTRY words, compares each
//   accepted word against every valid entry and reports the longest run of
//   matching MS bytes plus the winning entry index.
// Ports
//   i_clk    : clock, all state on rising edge
//   i_rst_n  : asynchronous reset, active low
//   bus      : dict_match_pipe_if.slave (word in / result out handshakes)
module dict_match_pipe #(
  parameter int WORD            = 32,
  parameter int DICT_ENTRY      = 16,
  parameter int MIN_MATCH_BYTES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  dict_match_pipe_if.slave  bus
);
  localparam int NB  = WORD/8;
  localparam int MBW = $clog2(NB + 1);
  localparam int LW  = $clog2(DICT_ENTRY);

  // dictionary
  logic [WORD-1:0]       ent_q [DICT_ENTRY];
  logic [WORD-1:0]       ent_d [DICT_ENTRY];
  logic [DICT_ENTRY-1:0] vld_q, vld_d;
  logic [LW-1:0]         wptr_q, wptr_d;

  // stage 1: per-entry byte counts + word
  logic                  s1_valid_q, s1_valid_d;
  logic [WORD-1:0]       s1_word_q, s1_word_d;
  logic                  s1_zero_q, s1_zero_d;
  logic [MBW-1:0]        s1_cnt_q [DICT_ENTRY];
  logic [MBW-1:0]        s1_cnt_d [DICT_ENTRY];

  // stage 2: reduced winner
  logic                  s2_valid_q, s2_valid_d;
  logic [MBW-1:0]        s2_bytes_q, s2_bytes_d;
  logic [LW-1:0]         s2_loc_q, s2_loc_d;
  logic [WORD-1:0]       s2_word_q, s2_word_d;

  logic                  advance;
  logic                  accept;
  logic                  full_hit;
  logic [MBW-1:0]        cur_cnt [DICT_ENTRY];
  logic [MBW-1:0]        best_cnt;
  logic [LW-1:0]         best_loc;

  assign advance = !s2_valid_q || bus.i_ready;
  assign accept  = bus.i_valid && advance;

  // Compare the incoming word against the dictionary as it stands now,
  // i.e. before this word's own push.
  always_comb begin
    full_hit = 1'b0;
    for (int e = 0; e < DICT_ENTRY; e++) begin
      logic [MBW-1:0] run_cnt;
      logic           run;
      run_cnt = '0;
      run     = 1'b1;
      for (int b = NB-1; b >= 0; b--) begin
        if (run && (ent_q[e][8*b +: 8] == bus.i_word[8*b +: 8])) begin
          run_cnt = run_cnt + MBW'(1);
        end else begin
          run = 1'b0;
        end
      end
      if (!vld_q[e] || (run_cnt < MBW'(MIN_MATCH_BYTES))) begin
        cur_cnt[e] = '0;
      end else begin
        cur_cnt[e] = run_cnt;
      end
      if (vld_q[e] && (ent_q[e] == bus.i_word)) begin
        full_hit = 1'b1;
      end
    end
  end

  // Strictly-greater scan keeps the lowest index on ties; a zero best count
  // leaves the location at 0.
  always_comb begin
    best_cnt = '0;
    best_loc = '0;
    for (int e = 0; e < DICT_ENTRY; e++) begin
      if (s1_cnt_q[e] > best_cnt) begin
        best_cnt = s1_cnt_q[e];
        best_loc = LW'(e);
      end
    end
    if (s1_zero_q) begin
      best_cnt = '0;
      best_loc = '0;
    end
  end

  always_comb begin
    ent_d      = ent_q;
    vld_d      = vld_q;
    wptr_d     = wptr_q;
    s1_valid_d = s1_valid_q;
    s1_word_d  = s1_word_q;
    s1_zero_d  = s1_zero_q;
    s1_cnt_d   = s1_cnt_q;
    s2_valid_d = s2_valid_q;
    s2_bytes_d = s2_bytes_q;
    s2_loc_d   = s2_loc_q;
    s2_word_d  = s2_word_q;

    if (advance) begin
      s1_valid_d = accept;
      s1_word_d  = bus.i_word;
      s1_zero_d  = bus.i_zero_hit;
      s1_cnt_d   = cur_cnt;
      s2_valid_d = s1_valid_q;
      s2_bytes_d = best_cnt;
      s2_loc_d   = best_loc;
      s2_word_d  = s1_word_q;

      // Flush has priority over the push of a word accepted in the same cycle.
      if (bus.i_flush) begin
        vld_d  = '0;
        wptr_d = '0;
      end else if (accept && !bus.i_zero_hit && !full_hit) begin
        ent_d[wptr_q] = bus.i_word;
        vld_d[wptr_q] = 1'b1;
        wptr_d        = wptr_q + LW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int e = 0; e < DICT_ENTRY; e++) begin
        ent_q[e]    <= '0;
        s1_cnt_q[e] <= '0;
      end
      vld_q      <= '0;
      wptr_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
      s1_zero_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_bytes_q <= '0;
      s2_loc_q   <= '0;
      s2_word_q  <= '0;
    end else begin
      ent_q      <= ent_d;
      s1_cnt_q   <= s1_cnt_d;
      vld_q      <= vld_d;
      wptr_q     <= wptr_d;
      s1_valid_q <= s1_valid_d;
      s1_word_q  <= s1_word_d;
      s1_zero_q  <= s1_zero_d;
      s2_valid_q <= s2_valid_d;
      s2_bytes_q <= s2_bytes_d;
      s2_loc_q   <= s2_loc_d;
      s2_word_q  <= s2_word_d;
    end
  end

  assign bus.o_ready       = advance;
  assign bus.o_valid       = s2_valid_q;
  assign bus.o_match_bytes = s2_bytes_q;
  assign bus.o_location    = s2_loc_q;
  assign bus.o_word        = s2_word_q;

endmodule

// File: tb/tb_dict_match_pipe.sv
module tb_dict_match_pipe;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct {
    logic [2:0]  mb;
    logic [3:0]  loc;
    logic [31:0] w;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_ent [16];
  logic [15:0] m_vld;
  logic [3:0]  m_wptr;

  dict_match_pipe_if #(.WORD(32), .DICT_ENTRY(16)) bus ();

  dict_match_pipe #(.WORD(32), .DICT_ENTRY(16), .MIN_MATCH_BYTES(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: byte run length by comparing progressively wider MS slices.
  function automatic exp_t model_match(input logic [31:0] w, input logic z);
    exp_t r;
    r.mb  = 3'd0;
    r.loc = 4'd0;
    r.w   = w;
    if (!z) begin
      for (int e = 0; e < 16; e++) begin
        int c;
        c = 0;
        if (m_vld[e]) begin
          for (int n = 1; n <= 4; n++) begin
            if (((m_ent[e] ^ w) >> (32 - 8*n)) == 32'd0) c = n;
          end
        end
        if (c < 2) c = 0;
        if (c > int'(r.mb)) begin
          r.mb  = 3'(c);
          r.loc = 4'(e);
        end
      end
    end
    return r;
  endfunction

  task automatic model_clear();
    m_vld  = '0;
    m_wptr = '0;
    for (int e = 0; e < 16; e++) m_ent[e] = '0;
  endtask

  // Monitor: sample mid-cycle; transfers occur at the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_valid && bus.i_ready) begin
        chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("match_bytes", 64'(bus.o_match_bytes), 64'(e.mb));
          chk("location",    64'(bus.o_location),    64'(e.loc));
          chk("word",        64'(bus.o_word),        64'(e.w));
        end
      end
      if (bus.o_ready) begin
        if (bus.i_valid) begin
          exp_t r;
          logic hit;
          r = model_match(bus.i_word, bus.i_zero_hit);
          sb.push_back(r);
          hit = 1'b0;
          for (int e = 0; e < 16; e++) if (m_vld[e] && m_ent[e] == bus.i_word) hit = 1'b1;
          if (!bus.i_flush && !bus.i_zero_hit && !hit) begin
            m_ent[m_wptr] = bus.i_word;
            m_vld[m_wptr] = 1'b1;
            m_wptr        = m_wptr + 4'd1;
          end
        end
        if (bus.i_flush) begin
          m_vld  = '0;
          m_wptr = '0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic z, input logic f);
    int  n;
    bit  got;
    bus.i_valid    = 1'b1;
    bus.i_word     = w;
    bus.i_zero_hit = z;
    bus.i_flush    = f;
    got = 1'b0;
    n   = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (bus.o_ready) got = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    bus.i_valid    = 1'b0;
    bus.i_zero_hit = 1'b0;
    bus.i_flush    = 1'b0;
    chk("accept_in_time", 64'(got), 64'd1);
  endtask

  task automatic flush_only();
    int n;
    bit got;
    bus.i_flush = 1'b1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (bus.o_ready) got = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    bus.i_flush = 1'b0;
    chk("flush_in_time", 64'(got), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_dict(input string tag);
    chk({tag, "_wptr"}, 64'(dut.wptr_q), 64'(m_wptr));
    chk({tag, "_vld"},  64'(dut.vld_q),  64'(m_vld));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_clear();
    rst_n          = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_word     = '0;
    bus.i_zero_hit = 1'b0;
    bus.i_flush    = 1'b0;
    bus.i_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", 64'(bus.o_valid),       64'd0);
    chk("rst_o_bytes", 64'(bus.o_match_bytes), 64'd0);
    chk("rst_o_loc",   64'(bus.o_location),    64'd0);
    chk("rst_o_word",  64'(bus.o_word),        64'd0);
    chk("rst_o_ready", 64'(bus.o_ready),       64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: repeat word -> (0,0) then (4,0), single entry stored
    send(32'h11223344, 1'b0, 1'b0);
    send(32'h11223344, 1'b0, 1'b0);
    drain();
    chk("t1_wptr", 64'(dut.wptr_q), 64'd1);
    chk("t1_vld",  64'(dut.vld_q),  64'd1);

    // 2: partial matches and MIN_MATCH_BYTES floor
    flush_only();
    send(32'hAABBCCDD, 1'b0, 1'b0);
    send(32'hAABBCC00, 1'b0, 1'b0);
    send(32'hAA000000, 1'b0, 1'b0);
    drain();
    chk("t2_wptr", 64'(dut.wptr_q), 64'd3);
    chk_dict("t2");

    // 3: fill, wrap and overwrite entry 0
    flush_only();
    for (int i = 0; i < 16; i++) send({8'(i + 1), 24'h5A5A5A}, 1'b0, 1'b0);
    send(32'h775A5A5A, 1'b0, 1'b0);
    drain();
    chk("t3_wptr", 64'(dut.wptr_q), 64'd1);
    send(32'h015A5A5A, 1'b0, 1'b0);
    drain();
    chk_dict("t3");

    // 4: tie between entries 3 and 9, then zero_hit on a full-hit word
    flush_only();
    for (int i = 0; i < 10; i++) begin
      if (i == 3)      send(32'hCAFE0001, 1'b0, 1'b0);
      else if (i == 9) send(32'hCAFE0002, 1'b0, 1'b0);
      else             send({8'(i + 8'h20), 24'h000000}, 1'b0, 1'b0);
    end
    send(32'hCAFE1234, 1'b0, 1'b0);
    send(32'hCAFE0001, 1'b1, 1'b0);
    drain();
    chk_dict("t4");

    // 5: downstream stall with a pending word
    bus.i_ready = 1'b0;
    send(32'hCAFE5555, 1'b0, 1'b0);
    send(32'h20000000, 1'b0, 1'b0);
    bus.i_valid = 1'b1;
    bus.i_word  = 32'hCAFE0002;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_stall_ready", 64'(bus.o_ready), 64'd0);
      chk("t5_stall_wptr",  64'(dut.wptr_q),  64'(m_wptr));
      @(posedge clk);
      #1;
    end
    bus.i_ready = 1'b1;
    send(32'hCAFE0002, 1'b0, 1'b0);
    drain();
    chk_dict("t5");

    // 6: flush with an accepted new word uses the old dictionary
    send(32'hCAFE9999, 1'b0, 1'b1);
    chk("t6_vld",  64'(dut.vld_q),  64'd0);
    chk("t6_wptr", 64'(dut.wptr_q), 64'd0);
    drain();

    // reset mid-stream
    send(32'h12345678, 1'b0, 1'b0);
    send(32'h12340000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_o_valid", 64'(bus.o_valid), 64'd0);
    sb.delete();
    model_clear();
    chk("t6_rst_vld", 64'(dut.vld_q), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'h12345678, 1'b0, 1'b0);
    drain();
    chk_dict("t6_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
